// File: rtl/config_frame_loader_pkg.sv
// Shared constants, header field positions and FSM states for the config frame loader.
package config_loader_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  localparam int HDR_COL_MSB   = 31;
  localparam int HDR_COL_LSB   = 24;
  localparam int HDR_FRAME_MSB = 20;
  localparam int HDR_FRAME_LSB = 16;
  localparam int COL_W         = HDR_COL_MSB - HDR_COL_LSB + 1;
  localparam int FRAME_W       = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    COMMIT
  } state_t;

endpackage

// File: rtl/config_frame_loader_if.sv
// Word-stream input and frame-write output bundle of the config frame loader.
// frames_written exists only when CONFIG_FRAME_COUNT_EN is defined.
interface config_frame_loader_if #(
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COLS       = 8,
  parameter int FRAMES_PER_COL = 20
);

  logic                               word_strobe;
  logic [31:0]                        word_data;
  logic                               link_active;
  logic [NUM_ROWS*32-1:0]             frame_data;
  logic [NUM_COLS*FRAMES_PER_COL-1:0] frame_strobe;
  logic                               busy;
  logic                               error;
`ifdef CONFIG_FRAME_COUNT_EN
  logic [15:0]                        frames_written;

  modport master (
    output word_strobe, word_data, link_active,
    input  frame_data, frame_strobe, busy, error, frames_written
  );

  modport slave (
    input  word_strobe, word_data, link_active,
    output frame_data, frame_strobe, busy, error, frames_written
  );
`else
  modport master (
    output word_strobe, word_data, link_active,
    input  frame_data, frame_strobe, busy, error
  );

  modport slave (
    input  word_strobe, word_data, link_active,
    output frame_data, frame_strobe, busy, error
  );
`endif

endinterface

// File: rtl/config_frame_loader_strobe.sv
// Registered one-hot write strobe for the addressed column/frame.
module frame_strobe_decoder
  import config_loader_pkg::*;
#(
  parameter int NUM_COLS       = 8,
  parameter int FRAMES_PER_COL = 20
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [COL_W-1:0]                   col,
  input  logic [FRAME_W-1:0]                 frame,
  input  logic                               fire,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] frame_strobe
);

  int idx;

  always_comb begin
    idx = int'(col) * FRAMES_PER_COL + int'(frame);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_COLS * FRAMES_PER_COL; i++) begin
        frame_strobe[i] <= fire && (i == idx);
      end
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Parses the receiver word stream (sync, header, data) into one-hot frame writes.
// Define CONFIG_FRAME_COUNT_EN to add the saturating frames_written counter.
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COLS       = 8,
  parameter int FRAMES_PER_COL = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  config_frame_loader_if.slave bus
);

  localparam int                 CNT_W       = $clog2(NUM_ROWS + 1);
  localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]   COL_LIMIT   = COL_W'(NUM_COLS);
  localparam logic [FRAME_W-1:0] FRAME_LIMIT = FRAME_W'(FRAMES_PER_COL);

  state_t                             state;
  logic [CNT_W-1:0]                   word_cnt;
  logic [COL_W-1:0]                   col_q;
  logic [FRAME_W-1:0]                 frame_q;
  logic [COL_W-1:0]                   hdr_col;
  logic [FRAME_W-1:0]                 hdr_frame;
  logic [NUM_ROWS*32-1:0]             frame_data;
  logic [NUM_COLS*FRAMES_PER_COL-1:0] frame_strobe;
  logic                               busy;
  logic                               error;
  logic                               fire;

  assign hdr_col   = bus.word_data[HDR_COL_MSB:HDR_COL_LSB];
  assign hdr_frame = bus.word_data[HDR_FRAME_MSB:HDR_FRAME_LSB];

  // Fire on the last data word so the registered strobe lines up with COMMIT.
  assign fire = (state == DATA) && bus.word_strobe && bus.link_active
                && (word_cnt == LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      col_q      <= '0;
      frame_q    <= '0;
      frame_data <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else if (state != IDLE && !bus.link_active) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.word_strobe && bus.word_data == SYNC_WORD) begin
            state <= HEADER;
            busy  <= 1'b1;
            error <= 1'b0;
          end
        end
        HEADER: begin
          if (bus.word_strobe) begin
            if (bus.word_data == DESYNC_WORD) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (hdr_col >= COL_LIMIT || hdr_frame >= FRAME_LIMIT) begin
              state <= IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state    <= DATA;
              col_q    <= hdr_col;
              frame_q  <= hdr_frame;
              word_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (bus.word_strobe) begin
            frame_data <= {frame_data[NUM_ROWS*32-33:0], bus.word_data};
            word_cnt   <= word_cnt + CNT_W'(1);
            if (word_cnt == LAST_WORD) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          state <= HEADER;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  frame_strobe_decoder #(
    .NUM_COLS       (NUM_COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) u_strobe (
    .clk          (clk),
    .reset        (reset),
    .col          (col_q),
    .frame        (frame_q),
    .fire         (fire),
    .frame_strobe (frame_strobe)
  );

  assign bus.frame_data   = frame_data;
  assign bus.frame_strobe = frame_strobe;
  assign bus.busy         = busy;
  assign bus.error        = error;

`ifdef CONFIG_FRAME_COUNT_EN
  logic [15:0] frames_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_cnt <= '0;
    end else if (state == COMMIT && frames_cnt != 16'hFFFF) begin
      frames_cnt <= frames_cnt + 16'd1;
    end
  end

  assign bus.frames_written = frames_cnt;
`endif

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: directed word streams, monitor checks each strobe.
module tb_config_frame_loader;
  import config_loader_pkg::*;

  localparam int NUM_ROWS       = 16;
  localparam int NUM_COLS       = 8;
  localparam int FRAMES_PER_COL = 20;
  localparam int DW             = NUM_ROWS * 32;
  localparam int SW             = NUM_COLS * FRAMES_PER_COL;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [SW-1:0] mon_oh;
  int            tests_run    = 0;
  int            tests_failed = 0;

  config_frame_loader_if #(
    .NUM_ROWS       (NUM_ROWS),
    .NUM_COLS       (NUM_COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) bus ();

  config_frame_loader #(
    .NUM_ROWS       (NUM_ROWS),
    .NUM_COLS       (NUM_COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] w);
    @(negedge clk);
    bus.word_data   = w;
    bus.word_strobe = 1'b1;
    @(negedge clk);
    bus.word_strobe = 1'b0;
  endtask

  // Header plus NUM_ROWS words; optionally embeds DESYNC/SYNC as plain data.
  task automatic send_frame(input logic [31:0] hdr, input int idx,
                            input logic [31:0] base, input bit ctrl_as_data);
    exp_t        e;
    logic [31:0] words[NUM_ROWS];
    e.idx  = idx;
    e.data = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      words[k] = base + 32'(k);
      if (ctrl_as_data && k == 0) words[k] = DESYNC_WORD;
      if (ctrl_as_data && k == 1) words[k] = SYNC_WORD;
      e.data[(NUM_ROWS-1-k)*32 +: 32] = words[k];
    end
    exp_q.push_back(e);
    apply_stimulus(hdr);
    for (int k = 0; k < NUM_ROWS; k++) begin
      apply_stimulus(words[k]);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_strobe != '0) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_strobe: got %h, expected none", bus.frame_strobe);
      end else begin
        mon_e     = exp_q.pop_front();
        mon_oh    = '0;
        mon_oh[mon_e.idx] = 1'b1;
        check_output("strobe_onehot", DW'(bus.frame_strobe), DW'(mon_oh));
        check_output("frame_data", bus.frame_data, mon_e.data);
        check_output("busy_at_strobe", DW'(bus.busy), DW'(1'b1));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] abort_exp;

    bus.word_strobe = 1'b0;
    bus.word_data   = '0;
    bus.link_active = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_frame_data", bus.frame_data, '0);
    check_output("reset_strobe", DW'(bus.frame_strobe), '0);
    check_output("reset_busy", DW'(bus.busy), '0);
    check_output("reset_error", DW'(bus.error), '0);
    reset = 1'b0;

    // Basic frame, then two back-to-back frames and DESYNC
    apply_stimulus(SYNC_WORD);
    check_output("busy_after_sync", DW'(bus.busy), DW'(1'b1));
    send_frame(32'h0203_0000, 43, 32'h0000_1000, 1'b0);
    send_frame(32'h0000_0000, 0, 32'h0000_3000, 1'b1);
    send_frame(32'h0713_0000, 159, 32'h0000_4000, 1'b0);
    check_output("busy_before_desync", DW'(bus.busy), DW'(1'b1));
    apply_stimulus(DESYNC_WORD);
    check_output("busy_after_desync", DW'(bus.busy), '0);

    // Bad headers: column out of range, then frame out of range
    apply_stimulus(SYNC_WORD);
    apply_stimulus(32'h0800_0000);
    check_output("error_bad_col", DW'(bus.error), DW'(1'b1));
    check_output("busy_bad_col", DW'(bus.busy), '0);
    apply_stimulus(32'h1234_5678);
    check_output("error_sticky", DW'(bus.error), DW'(1'b1));
    check_output("busy_idle_word", DW'(bus.busy), '0);
    apply_stimulus(SYNC_WORD);
    check_output("error_cleared_sync", DW'(bus.error), '0);
    check_output("busy_resync", DW'(bus.busy), DW'(1'b1));
    apply_stimulus(32'h0014_0000);
    check_output("error_bad_frame", DW'(bus.error), DW'(1'b1));
    apply_stimulus(SYNC_WORD);
    check_output("error_cleared_again", DW'(bus.error), '0);

    // Abort after 5 data words; a word strobed with the abort is dropped
    apply_stimulus(32'h0105_0000);
    abort_exp = '0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(32'h0000_5000 + 32'(k));
      abort_exp[(4-k)*32 +: 32] = 32'h0000_5000 + 32'(k);
    end
    @(negedge clk);
    bus.link_active = 1'b0;
    bus.word_data   = 32'hDEAD_BEEF;
    bus.word_strobe = 1'b1;
    @(negedge clk);
    bus.word_strobe = 1'b0;
    check_output("busy_after_abort", DW'(bus.busy), '0);
    check_output("error_after_abort", DW'(bus.error), '0);
    check_output("data_retained_abort", DW'(bus.frame_data[159:0]), abort_exp);
    bus.link_active = 1'b1;
    apply_stimulus(SYNC_WORD);
    send_frame(32'h01E3_FFFF, 23, 32'h0000_6000, 1'b0);
    apply_stimulus(DESYNC_WORD);

    // Reset after 10 data words
    apply_stimulus(SYNC_WORD);
    apply_stimulus(32'h0406_0000);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(32'h0000_7000 + 32'(k));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_frame_data", bus.frame_data, '0);
    check_output("midreset_strobe", DW'(bus.frame_strobe), '0);
    check_output("midreset_busy", DW'(bus.busy), '0);
    check_output("midreset_error", DW'(bus.error), '0);
`ifdef CONFIG_FRAME_COUNT_EN
    check_output("midreset_count", DW'(bus.frames_written), '0);
`endif
    reset = 1'b0;
    for (int k = 10; k < NUM_ROWS; k++) begin
      apply_stimulus(32'h0000_7000 + 32'(k));
    end
    check_output("busy_after_reset_words", DW'(bus.busy), '0);

`ifdef CONFIG_FRAME_COUNT_EN
    apply_stimulus(SYNC_WORD);
    send_frame(32'h0000_0000, 0, 32'h0000_8000, 1'b0);
    send_frame(32'h0101_0000, 21, 32'h0000_8100, 1'b0);
    send_frame(32'h0302_0000, 62, 32'h0000_8200, 1'b0);
    apply_stimulus(DESYNC_WORD);
    check_output("count_three", DW'(bus.frames_written), DW'(16'd3));
    force dut.frames_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frames_cnt;
    apply_stimulus(SYNC_WORD);
    send_frame(32'h0000_0000, 0, 32'h0000_9000, 1'b0);
    send_frame(32'h0000_0000, 0, 32'h0000_9100, 1'b0);
    apply_stimulus(DESYNC_WORD);
    check_output("count_saturate", DW'(bus.frames_written), DW'(16'hFFFF));
`endif

    repeat (4) @(negedge clk);
    check_output("pending_strobes", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
# config_frame_loader

Consumes the 32-bit word stream produced by the serial configuration receiver (one-cycle `word_strobe` plus `word_data`, qualified by `link_active`) and turns it into fabric configuration writes. Words are parsed by a state machine into sync, frame header and frame data. Each completed frame is presented as a wide `frame_data` bus plus a one-cycle, one-hot `frame_strobe` for the addressed column/frame. Sits between the serial receiver and the fabric frame registers.

## Interface
- `NUM_ROWS`, 16, data words per frame; `frame_data` width is `NUM_ROWS*32`
- `NUM_COLS`, 8, fabric columns addressable
- `FRAMES_PER_COL`, 20, frames per column
- `clk` input 1: sole clock, all logic on the rising edge
- `reset` input 1: synchronous, active-high reset
- `word_strobe` input 1: one-cycle pulse, `word_data` valid
- `word_data` input 32: received word
- `link_active` input 1: receiver session active
- `frame_data` output `NUM_ROWS*32`: assembled frame; word 0 lands in the MSB word
- `frame_strobe` output `NUM_COLS*FRAMES_PER_COL`: one-hot write pulse; bit index = `col*FRAMES_PER_COL + frame`
- `busy` output 1: high in any state other than IDLE
- `error` output 1: sticky; cleared only by `reset` or a new sync word
- `frames_written` output 16: present only with `CONFIG_FRAME_COUNT_EN`

## Operation
- Constants:
  - SYNC = 32'hFAB0_FAB1
  - DESYNC = 32'hFAB0_FAB0
- Header word format:
  - `[31:24]` = column
  - `[20:16]` = frame
  - all other bits ignored
- States: IDLE, HEADER, DATA, COMMIT.
- **IDLE**
  - A strobed word equal to SYNC → HEADER, clears `error`.
  - Any other word is ignored.
- **HEADER**
  - A strobed DESYNC → IDLE.
  - Otherwise the word is decoded as a header.
  - If column ≥ `NUM_COLS` or frame ≥ `FRAMES_PER_COL`: set `error`, go to IDLE.
  - Otherwise latch the address, clear the word counter, go to DATA.
- **DATA**
  - Each strobed word shifts into `frame_data`: `frame_data <= {frame_data[NUM_ROWS*32-33:0], word_data}`.
  - The word counter increments.
  - On word `NUM_ROWS` (counter == `NUM_ROWS-1` at the strobe) → COMMIT.
  - SYNC or DESYNC values received in DATA are data, not control.
- **COMMIT**
  - Lasts exactly one cycle.
  - Drives `frame_strobe` bit for the latched address high, all other bits low.
  - Then → HEADER (next frame header, or DESYNC).
  - A `word_strobe` in this cycle is illegal by protocol and is ignored.
- `link_active` low in any state other than IDLE: abort to IDLE next cycle.
  - No strobe is issued.
  - `frame_data` is retained.
  - `error` is not set.
- Word counter width is `$clog2(NUM_ROWS+1)`. It never wraps: it is cleared on entry to DATA.
- Reset values:
  - state IDLE
  - `frame_data` 0
  - `frame_strobe` all 0
  - `busy` 0
  - `error` 0
  - `frames_written` 0

## Timing
- Last data word strobed in cycle N → `frame_strobe` high in cycle N+1, only that cycle.
- `frame_data` is stable from cycle N+1 until the next DATA-state strobe. Consumers may capture it on the strobe edge.
- `busy` rises the cycle after the SYNC strobe and falls the cycle after DESYNC, error or abort.
- `error` is set the cycle after the bad header strobe.
- Minimum word spacing is 2 cycles; this is guaranteed by the upstream receiver.
- Reset asserted mid-frame: no strobe is emitted. All outputs take their reset values in the next cycle.
- Abort and a valid `word_strobe` in the same cycle: the abort wins and the word is dropped.

## Configuration
- `CONFIG_FRAME_COUNT_EN` defined:
  - Adds `frames_written`, which increments on every COMMIT cycle and saturates at 16'hFFFF.
  - Reset clears it; a sync word does not.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `config_loader_pkg` holds:
  - SYNC and DESYNC constants
  - header field bit positions
  - the state enum
- Sub-module `frame_strobe_decoder`:
  - Inputs: column, frame, `fire`.
  - Output: the registered one-hot `frame_strobe`.
  - Parameterised by `NUM_COLS` and `FRAMES_PER_COL`.
- Everything else lives in the top-level FSM.

## Test plan
- **Basic frame.** Drive SYNC, header 32'h0203_0000 (col 2, frame 3), then 16 words 0x1000..0x100F. Require:
  - a single-cycle pulse on `frame_strobe` bit 43
  - `frame_data` = {0x1000,...,0x100F}
  - `busy`=1
- **Back-to-back frames.** SYNC, two header+16-word frames (col 0 frame 0, col 7 frame 19), then DESYNC. Require:
  - pulses on bits 0 and 159 only
  - `busy` falls after DESYNC
- **Bad header.** SYNC, header col 8. Require:
  - `error`=1, state IDLE, no strobe
  - a subsequent SYNC clears `error`
- **Abort.** Drop `link_active` after 5 data words. Require:
  - no strobe, `busy`=0 next cycle
  - a new SYNC+frame commits normally
- **Reset mid-frame.** Assert `reset` after 10 data words. Require all outputs zero, with no strobe.
- **Counter.** With `CONFIG_FRAME_COUNT_EN`, three frames → `frames_written`=3. Preload near 16'hFFFF → saturates.
